// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note ON/OFF events onto NUM_VOICES voices.
// Each ON first retriggers a voice already holding the note, else reuses the oldest released voice, else steals the oldest voice.
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int DATA_WIDTH = 7
) (
   input  logic                             clock_50_000_000,
   input  logic                             reset_l,
   input  logic                             note_ready,
   input  logic                             note_on,
   input  logic [DATA_WIDTH-1:0]            note_number,
   input  logic [DATA_WIDTH-1:0]            note_velocity,
   output logic                             note_drop,
   output logic                             busy,
   output logic [NUM_VOICES-1:0]            voice_gate,
   output logic [NUM_VOICES-1:0]            voice_clear,
   output logic [NUM_VOICES*DATA_WIDTH-1:0] voice_note,
   output logic [NUM_VOICES*DATA_WIDTH-1:0] voice_velocity
);

   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_APPLY  = 2'd2;

   logic [1:0]            state;
   logic                  slot_valid;
   logic                  slot_on;
   logic [DATA_WIDTH-1:0] slot_number;
   logic [DATA_WIDTH-1:0] slot_velocity;
   logic                  ev_on;
   logic [DATA_WIDTH-1:0] ev_number;
   logic [DATA_WIDTH-1:0] ev_velocity;
   logic                  tgt_valid;
   logic [IW-1:0]         tgt;
   logic [NUM_VOICES-1:0] used;
   logic [IW-1:0]         rank [NUM_VOICES];

   logic                  consume;
   logic                  hit_found;
   logic [IW-1:0]         hit_idx;
   logic                  rel_found;
   logic [IW-1:0]         rel_idx;
   logic [IW-1:0]         rel_rank;
   logic [IW-1:0]         old_idx;
   logic                  nxt_valid;
   logic [IW-1:0]         nxt_tgt;

   assign consume = (state == S_IDLE) && slot_valid;
   assign busy    = (state != S_IDLE) || slot_valid;

   // A strobe may load the slot on the same edge the FSM empties it.
   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         slot_valid    <= 1'b0;
         slot_on       <= 1'b0;
         slot_number   <= '0;
         slot_velocity <= '0;
         note_drop     <= 1'b0;
      end else begin
         note_drop <= note_ready && slot_valid && !consume;
         if (note_ready && (!slot_valid || consume)) begin
            slot_valid    <= 1'b1;
            slot_on       <= note_on && (note_velocity != '0);
            slot_number   <= note_number;
            slot_velocity <= note_velocity;
         end else if (consume) begin
            slot_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      hit_found = 1'b0;
      hit_idx   = '0;
      rel_found = 1'b0;
      rel_idx   = '0;
      rel_rank  = '0;
      old_idx   = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (!hit_found && used[v] && (voice_note[v*DATA_WIDTH +: DATA_WIDTH] == ev_number)) begin
            hit_found = 1'b1;
            hit_idx   = IW'(v);
         end
         if (used[v] && !voice_gate[v] && (!rel_found || (rank[v] > rel_rank))) begin
            rel_found = 1'b1;
            rel_idx   = IW'(v);
            rel_rank  = rank[v];
         end
         if (rank[v] == IW'(NUM_VOICES - 1)) begin
            old_idx = IW'(v);
         end
      end
      if (ev_on) begin
         nxt_valid = 1'b1;
         nxt_tgt   = hit_found ? hit_idx : (rel_found ? rel_idx : old_idx);
      end else begin
         nxt_valid = hit_found && voice_gate[hit_idx];
         nxt_tgt   = hit_idx;
      end
   end

   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         state       <= S_IDLE;
         ev_on       <= 1'b0;
         ev_number   <= '0;
         ev_velocity <= '0;
         tgt_valid   <= 1'b0;
         tgt         <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (slot_valid) begin
                  ev_on       <= slot_on;
                  ev_number   <= slot_number;
                  ev_velocity <= slot_velocity;
                  state       <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               tgt_valid <= nxt_valid;
               tgt       <= nxt_tgt;
               state     <= S_APPLY;
            end
            S_APPLY: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Voice 0 starts as the oldest so that fresh voices fill in index order.
   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         voice_gate     <= '0;
         voice_clear    <= '0;
         voice_note     <= '0;
         voice_velocity <= '0;
         used           <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            rank[v] <= IW'(NUM_VOICES - 1 - v);
         end
      end else begin
         voice_clear <= '0;
         if ((state == S_APPLY) && tgt_valid) begin
            if (ev_on) begin
               voice_note[tgt*DATA_WIDTH +: DATA_WIDTH]     <= ev_number;
               voice_velocity[tgt*DATA_WIDTH +: DATA_WIDTH] <= ev_velocity;
               voice_gate[tgt]  <= 1'b1;
               used[tgt]        <= 1'b1;
               voice_clear[tgt] <= 1'b1;
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (IW'(v) == tgt) begin
                     rank[v] <= '0;
                  end else if (rank[v] < rank[tgt]) begin
                     rank[v] <= rank[v] + 1'b1;
                  end
               end
            end else begin
               voice_gate[tgt] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus randomized events against an age-ordered voice model.
module tb_voice_allocator;

   localparam int NV = 4;
   localparam int DW = 7;

   logic              clk = 1'b0;
   logic              reset_l = 1'b0;
   logic              note_ready = 1'b0;
   logic              note_on = 1'b0;
   logic [DW-1:0]     note_number = '0;
   logic [DW-1:0]     note_velocity = '0;
   logic              note_drop;
   logic              busy;
   logic [NV-1:0]     voice_gate;
   logic [NV-1:0]     voice_clear;
   logic [NV*DW-1:0]  voice_note;
   logic [NV*DW-1:0]  voice_velocity;

   int n_checks = 0;
   int n_pass = 0;

   voice_allocator #(.NUM_VOICES(NV), .DATA_WIDTH(DW)) dut (
      .clock_50_000_000 (clk),
      .reset_l          (reset_l),
      .note_ready       (note_ready),
      .note_on          (note_on),
      .note_number      (note_number),
      .note_velocity    (note_velocity),
      .note_drop        (note_drop),
      .busy             (busy),
      .voice_gate       (voice_gate),
      .voice_clear      (voice_clear),
      .voice_note       (voice_note),
      .voice_velocity   (voice_velocity)
   );

   always #10 clk = ~clk;

   // Model: per-voice state plus a list of voices ordered oldest first.
   logic [DW-1:0] m_note [NV];
   logic [DW-1:0] m_vel [NV];
   logic [NV-1:0] m_gate;
   logic [NV-1:0] m_used;
   logic [NV-1:0] m_clear;
   int            age_q[$];

   function automatic void model_reset();
      m_gate = '0;
      m_used = '0;
      m_clear = '0;
      age_q.delete();
      for (int v = 0; v < NV; v++) begin
         m_note[v] = '0;
         m_vel[v] = '0;
         age_q.push_back(v);
      end
   endfunction

   function automatic void model_event(input bit on, input logic [DW-1:0] n, input logic [DW-1:0] vel);
      int hit;
      int t;
      hit = -1;
      t = -1;
      m_clear = '0;
      if (vel == 0) on = 1'b0;
      for (int v = NV - 1; v >= 0; v--)
         if (m_used[v] && m_note[v] == n) hit = v;
      if (on) begin
         if (hit >= 0) t = hit;
         else begin
            foreach (age_q[i])
               if (t < 0 && m_used[age_q[i]] && !m_gate[age_q[i]]) t = age_q[i];
            if (t < 0) t = age_q[0];
         end
         m_note[t] = n;
         m_vel[t] = vel;
         m_gate[t] = 1'b1;
         m_used[t] = 1'b1;
         m_clear[t] = 1'b1;
         foreach (age_q[i])
            if (age_q[i] == t) begin
               age_q.delete(i);
               break;
            end
         age_q.push_back(t);
      end else if (hit >= 0 && m_gate[hit]) begin
         m_gate[hit] = 1'b0;
      end
   endfunction

   function automatic logic [NV*DW-1:0] flat_note();
      logic [NV*DW-1:0] r;
      for (int v = 0; v < NV; v++) r[v*DW +: DW] = m_note[v];
      return r;
   endfunction

   function automatic logic [NV*DW-1:0] flat_vel();
      logic [NV*DW-1:0] r;
      for (int v = 0; v < NV; v++) r[v*DW +: DW] = m_vel[v];
      return r;
   endfunction

   task automatic strobe(input bit on, input logic [DW-1:0] n, input logic [DW-1:0] vel);
      @(negedge clk);
      note_ready = 1'b1;
      note_on = on;
      note_number = n;
      note_velocity = vel;
      @(negedge clk);
      note_ready = 1'b0;
   endtask

   // Returns at the falling edge just after the edge that applies the event.
   task automatic play(input bit on, input logic [DW-1:0] n, input logic [DW-1:0] vel);
      model_event(on, n, vel);
      strobe(on, n, vel);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_l = 1'b0;
      note_ready = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      reset_l = 1'b1;
   endtask

   task automatic test_reset();
      reset_l = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({voice_gate, voice_clear, voice_note, voice_velocity, busy, note_drop} !== '0)
         $display("FAIL reset_outputs: gate=%b clear=%b note=%h vel=%h busy=%b drop=%b expected all 0",
                  voice_gate, voice_clear, voice_note, voice_velocity, busy, note_drop);
      else n_pass++;
      reset_l = 1'b1;
      model_event(1'b1, 7'd60, 7'd100);
      strobe(1'b1, 7'd60, 7'd100);
      repeat (2) @(negedge clk);
      n_checks++;
      if (voice_gate !== 4'b0000 || voice_clear !== 4'b0000 || busy !== 1'b1)
         $display("FAIL first_on_early: gate=%b clear=%b busy=%b expected 0000 0000 1", voice_gate, voice_clear, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (voice_gate !== 4'b0001 || voice_clear !== 4'b0001 || voice_note[DW-1:0] !== 7'd60 ||
          voice_velocity[DW-1:0] !== 7'd100 || voice_note !== flat_note())
         $display("FAIL first_on: gate=%b clear=%b note=%h vel=%h expected gate=0001 clear=0001 voice0 60/100",
                  voice_gate, voice_clear, voice_note, voice_velocity);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (voice_clear !== 4'b0000 || voice_gate !== 4'b0001 || busy !== 1'b0)
         $display("FAIL first_on_after: clear=%b gate=%b busy=%b expected 0000 0001 0", voice_clear, voice_gate, busy);
      else n_pass++;
   endtask

   task automatic test_steal();
      do_reset();
      play(1'b1, 7'd60, 7'd10);
      play(1'b1, 7'd62, 7'd20);
      play(1'b1, 7'd64, 7'd30);
      play(1'b1, 7'd67, 7'd40);
      n_checks++;
      if (voice_gate !== 4'b1111 || voice_note !== {7'd67, 7'd64, 7'd62, 7'd60} || voice_clear !== 4'b1000)
         $display("FAIL fill_four: gate=%b note=%h clear=%b expected 1111 %h 1000",
                  voice_gate, voice_note, voice_clear, {7'd67, 7'd64, 7'd62, 7'd60});
      else n_pass++;
      play(1'b1, 7'd69, 7'd50);
      n_checks++;
      if (voice_clear !== 4'b0001 || voice_note[DW-1:0] !== 7'd69 || voice_velocity[DW-1:0] !== 7'd50 ||
          voice_note !== flat_note() || voice_gate !== m_gate)
         $display("FAIL steal_oldest: clear=%b note=%h vel=%h gate=%b expected clear=0001 note=%h voice0 vel 50",
                  voice_clear, voice_note, voice_velocity, voice_gate, flat_note());
      else n_pass++;
      play(1'b0, 7'd60, 7'd0);
      n_checks++;
      if (voice_gate !== 4'b1111 || voice_clear !== 4'b0000 || voice_note !== flat_note())
         $display("FAIL stolen_off_ignored: gate=%b clear=%b note=%h expected 1111 0000 %h",
                  voice_gate, voice_clear, voice_note, flat_note());
      else n_pass++;
   endtask

   task automatic test_release();
      do_reset();
      play(1'b1, 7'd60, 7'd80);
      play(1'b1, 7'd62, 7'd81);
      play(1'b1, 7'd60, 7'd90);
      n_checks++;
      if (voice_clear !== 4'b0001 || voice_velocity[DW-1:0] !== 7'd90 || voice_gate !== 4'b0011)
         $display("FAIL retrigger_held: clear=%b vel=%h gate=%b expected 0001 voice0 vel 90 gate 0011",
                  voice_clear, voice_velocity, voice_gate);
      else n_pass++;
      play(1'b0, 7'd60, 7'd64);
      n_checks++;
      if (voice_gate !== 4'b0010 || voice_clear !== 4'b0000 || voice_note[DW-1:0] !== 7'd60 ||
          voice_velocity[DW-1:0] !== 7'd90)
         $display("FAIL off_release: gate=%b clear=%b note=%h vel=%h expected gate 0010, voice0 retains 60/90",
                  voice_gate, voice_clear, voice_note, voice_velocity);
      else n_pass++;
      play(1'b1, 7'd65, 7'd70);
      n_checks++;
      if (voice_clear !== 4'b0001 || voice_note[DW-1:0] !== 7'd65 || voice_gate !== 4'b0011 ||
          voice_velocity !== flat_vel())
         $display("FAIL reuse_released: clear=%b note=%h gate=%b vel=%h expected 0001 voice0=65 gate 0011 vel %h",
                  voice_clear, voice_note, voice_gate, voice_velocity, flat_vel());
      else n_pass++;
      play(1'b1, 7'd62, 7'd33);
      n_checks++;
      if (voice_clear !== 4'b0010 || voice_velocity[2*DW-1:DW] !== 7'd33 || voice_note !== flat_note())
         $display("FAIL retrigger_voice1: clear=%b vel=%h note=%h expected clear 0010 voice1 vel 33",
                  voice_clear, voice_velocity, voice_note);
      else n_pass++;
   endtask

   task automatic test_vel_zero();
      logic [NV*DW-1:0] snap_note;
      logic [NV*DW-1:0] snap_vel;
      do_reset();
      play(1'b1, 7'd60, 7'd100);
      play(1'b1, 7'd60, 7'd0);
      n_checks++;
      if (voice_gate !== 4'b0000 || voice_clear !== 4'b0000 || voice_note[DW-1:0] !== 7'd60 ||
          voice_velocity[DW-1:0] !== 7'd100)
         $display("FAIL vel_zero_is_off: gate=%b clear=%b note=%h vel=%h expected 0000 0000 voice0 60/100",
                  voice_gate, voice_clear, voice_note, voice_velocity);
      else n_pass++;
      snap_note = voice_note;
      snap_vel = voice_velocity;
      play(1'b0, 7'd50, 7'd40);
      n_checks++;
      if (voice_gate !== 4'b0000 || voice_clear !== 4'b0000 || voice_note !== snap_note || voice_velocity !== snap_vel)
         $display("FAIL off_unheld: gate=%b clear=%b note=%h vel=%h expected no change (note=%h vel=%h)",
                  voice_gate, voice_clear, voice_note, voice_velocity, snap_note, snap_vel);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      model_event(1'b1, 7'd60, 7'd11);
      model_event(1'b1, 7'd62, 7'd22);
      @(negedge clk);
      note_ready = 1'b1; note_on = 1'b1; note_number = 7'd60; note_velocity = 7'd11;
      @(negedge clk);
      note_number = 7'd62; note_velocity = 7'd22;
      @(negedge clk);
      n_checks++;
      if (note_drop !== 1'b0)
         $display("FAIL drop_early: note_drop=%b expected 0", note_drop);
      else n_pass++;
      note_number = 7'd64; note_velocity = 7'd33;
      @(negedge clk);
      note_ready = 1'b0;
      n_checks++;
      if (note_drop !== 1'b1 || busy !== 1'b1)
         $display("FAIL third_dropped: note_drop=%b busy=%b expected 1 1", note_drop, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (note_drop !== 1'b0 || voice_clear !== 4'b0001)
         $display("FAIL first_applied: note_drop=%b clear=%b expected 0 0001", note_drop, voice_clear);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (voice_clear !== m_clear || voice_gate !== m_gate || voice_note !== flat_note() || voice_velocity !== flat_vel())
         $display("FAIL second_applied: clear=%b gate=%b note=%h vel=%h expected %b %b %h %h",
                  voice_clear, voice_gate, voice_note, voice_velocity, m_clear, m_gate, flat_note(), flat_vel());
      else n_pass++;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || voice_gate !== 4'b0011)
         $display("FAIL idle_after_pair: busy=%b gate=%b expected 0 0011", busy, voice_gate);
      else n_pass++;
   endtask

   task automatic test_throughput();
      int drops;
      logic [DW-1:0] n;
      logic [DW-1:0] vel;
      do_reset();
      drops = 0;
      for (int i = 0; i < 12; i++) begin
         n = 7'($urandom_range(48, 56));
         vel = 7'($urandom_range(1, 127));
         model_event(1'b1, n, vel);
         @(negedge clk);
         note_ready = 1'b1; note_on = 1'b1; note_number = n; note_velocity = vel;
         @(negedge clk);
         note_ready = 1'b0;
         if (note_drop) drops++;
         @(negedge clk);
         if (note_drop) drops++;
      end
      repeat (6) @(negedge clk);
      if (note_drop) drops++;
      n_checks++;
      if (drops != 0)
         $display("FAIL sustained_rate: drops=%0d expected 0", drops);
      else n_pass++;
      n_checks++;
      if (voice_gate !== m_gate || voice_note !== flat_note() || voice_velocity !== flat_vel() || voice_clear !== 4'b0000)
         $display("FAIL sustained_state: gate=%b note=%h vel=%h clear=%b expected %b %h %h 0000",
                  voice_gate, voice_note, voice_velocity, voice_clear, m_gate, flat_note(), flat_vel());
      else n_pass++;
   endtask

   task automatic test_reset_mid_apply();
      do_reset();
      play(1'b1, 7'd60, 7'd100);
      strobe(1'b1, 7'd62, 7'd90);
      repeat (2) @(negedge clk);
      reset_l = 1'b0;
      #1;
      n_checks++;
      if ({voice_gate, voice_clear, voice_note, voice_velocity, busy, note_drop} !== '0)
         $display("FAIL reset_mid_apply: gate=%b clear=%b note=%h vel=%h busy=%b drop=%b expected all 0",
                  voice_gate, voice_clear, voice_note, voice_velocity, busy, note_drop);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({voice_gate, voice_clear, voice_note, voice_velocity} !== '0)
         $display("FAIL reset_no_partial: gate=%b clear=%b note=%h vel=%h expected all 0",
                  voice_gate, voice_clear, voice_note, voice_velocity);
      else n_pass++;
      model_reset();
      reset_l = 1'b1;
      play(1'b1, 7'd70, 7'd55);
      n_checks++;
      if (voice_gate !== 4'b0001 || voice_clear !== 4'b0001 || voice_note[DW-1:0] !== 7'd70 || voice_note !== flat_note())
         $display("FAIL on_after_reset: gate=%b clear=%b note=%h expected 0001 0001 voice0=70",
                  voice_gate, voice_clear, voice_note);
      else n_pass++;
   endtask

   task automatic test_random();
      bit on;
      logic [DW-1:0] n;
      logic [DW-1:0] vel;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         on = ($urandom_range(0, 9) < 7);
         n = 7'($urandom_range(60, 67));
         vel = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         play(on, n, vel);
         n_checks++;
         if (voice_gate !== m_gate || voice_clear !== m_clear || voice_note !== flat_note() || voice_velocity !== flat_vel())
            $display("FAIL random_event_%0d: gate=%b clear=%b note=%h vel=%h expected %b %b %h %h",
                     i, voice_gate, voice_clear, voice_note, voice_velocity, m_gate, m_clear, flat_note(), flat_vel());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_steal();
      test_release();
      test_vel_zero();
      test_back_to_back();
      test_throughput();
      test_reset_mid_apply();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
